// File: rtl/cd_limit_ctrl_pkg.sv
// rtl/cd_limit_ctrl_pkg.sv - shared CD parameters and limit-controller state encoding
package cd_limit_ctrl_pkg;

    localparam int CLK_MAX_WIDTH = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } cd_state_t;

endpackage

// File: rtl/cd_limit_ctrl_if.sv
// rtl/cd_limit_ctrl_if.sv - divide-ratio request handshake
interface cd_limit_ctrl_if
    import cd_limit_ctrl_pkg::*;
#(
    parameter int WIDTH = CLK_MAX_WIDTH
);

    logic             req_valid;
    logic [WIDTH-1:0] req_ratio;
    logic             req_ready;

    modport master (output req_valid, output req_ratio, input  req_ready);
    modport slave  (input  req_valid, input  req_ratio, output req_ready);

endinterface

// File: rtl/cd_limit_ctrl_phase_mirror.sv
// rtl/cd_limit_ctrl_phase_mirror.sv - mirror of the downstream divider counter, flags its wrap
module cd_phase_mirror
    import cd_limit_ctrl_pkg::*;
#(
    parameter int WIDTH = CLK_MAX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] limit,
    output logic             wrap
);

    logic [WIDTH-1:0] phase;

    // limit is never below 1, so limit-1 cannot underflow
    assign wrap = (phase >= (limit - WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (wrap) begin
            phase <= '0;
        end else begin
            phase <= phase + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cd_limit_ctrl.sv
// rtl/cd_limit_ctrl.sv - accepts divide ratios and applies them to the divider limit only at a wrap
module cd_limit_ctrl
    import cd_limit_ctrl_pkg::*;
#(
    parameter int          WIDTH       = CLK_MAX_WIDTH,
    parameter int unsigned RESET_LIMIT = 2,
    parameter int unsigned MIN_RATIO   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    cd_limit_ctrl_if.slave     req,
    output logic [WIDTH-1:0]   limit,
    output logic               busy,
    output logic               upd_done,
    output logic               err
);

    localparam logic [WIDTH-1:0] RST_LIM = WIDTH'(RESET_LIMIT);
    localparam logic [WIDTH-1:0] MIN_R   = WIDTH'(MIN_RATIO);

    cd_state_t        state, state_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic [WIDTH-1:0] limit_nxt;
    logic             err_nxt, done_nxt;
    logic             wrap;

    cd_phase_mirror #(.WIDTH(WIDTH)) u_mirror (
        .clk   (clk),
        .rst_n (rst_n),
        .limit (limit),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shadow   <= '0;
            limit    <= RST_LIM;
            err      <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            shadow   <= shadow_nxt;
            limit    <= limit_nxt;
            err      <= err_nxt;
            upd_done <= done_nxt;
        end
    end

    // A request taken on a wrap edge still waits for the next wrap: no bypass to limit.
    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        limit_nxt     = limit;
        err_nxt       = 1'b0;
        done_nxt      = 1'b0;
        req.req_ready = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    if (req.req_ratio < MIN_R) begin
                        err_nxt = 1'b1;
                    end else begin
                        shadow_nxt = req.req_ratio;
                        state_nxt  = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                busy = 1'b1;
                if (wrap) begin
                    limit_nxt = shadow;
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/cd_limit_ctrl.md
CD_LIMIT_CTRL -- requirements
Module: cd_limit_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default CLK_MAX_WIDTH (shared CD parameter, 32): width of the divide ratio and limit.
REQ-002 The block SHALL take parameter RESET_LIMIT, default 2: limit value driven out of reset.
REQ-003 The block SHALL take parameter MIN_RATIO, default 2: smallest divide ratio accepted; must be >= 1 and <= 2^WIDTH-1.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  new divide ratio offered.
REQ-008 req_ratio  input  WIDTH  requested divide ratio (counter limit).
REQ-009 req_ready  output  1  ratio can be accepted this cycle.
REQ-010 limit  output  WIDTH  limit driven to the downstream clock-divider counter.
REQ-011 busy  output  1  accepted ratio waiting to be applied.
REQ-012 upd_done  output  1  one-cycle pulse: new limit applied.
REQ-013 err  output  1  one-cycle pulse: request rejected (ratio < MIN_RATIO).

Function
REQ-014 The block SHALL keep a WIDTH-bit mirror phase counter equal, cycle for cycle, to the downstream counter: phase <= (phase >= limit-1) ? 0 : phase+1; wrap = (phase >= limit-1).
REQ-015 The block SHALL implement FSM states IDLE and PENDING; req_ready = 1 only in IDLE, busy = 1 only in PENDING.
REQ-016 A transfer SHALL occur when req_valid and req_ready are both high at a rising clk edge; req_ratio is sampled only then.
REQ-017 On a transfer with req_ratio < MIN_RATIO, the block SHALL assert err the following cycle for exactly one cycle, stay IDLE, and leave limit unchanged.
REQ-018 On a transfer with req_ratio >= MIN_RATIO, the block SHALL capture the ratio into a shadow register and enter PENDING on the same edge.
REQ-019 In PENDING, on the first edge where wrap is true, the block SHALL load limit from the shadow, reset phase to 0, return to IDLE, and assert upd_done for exactly the following cycle.
REQ-020 A transfer in IDLE on a wrap cycle SHALL NOT apply the ratio on that edge; it SHALL apply at the next wrap (no bypass path).
REQ-021 A ratio equal to the current limit SHALL follow the same PENDING path and pulse upd_done.
REQ-022 limit SHALL change only at a wrap edge, so the downstream counter never sees a limit below its current count.
REQ-023 All comparisons SHALL be unsigned WIDTH-bit; limit-1 never underflows because limit >= MIN_RATIO >= 1.
REQ-024 err and upd_done SHALL never be high in the same cycle.

Reset
REQ-025 While rst_n = 0: state IDLE, phase 0, limit = RESET_LIMIT, shadow 0, req_ready 1, busy 0, upd_done 0, err 0.
REQ-026 Reset asserted during PENDING SHALL discard the shadow ratio; no upd_done follows reset release.
REQ-027 After release, the first phase increment SHALL occur on the first rising clk edge, in step with the downstream counter released by the same reset.

Structure
REQ-028 CLK_MAX_WIDTH and the FSM state encoding SHALL live in the shared CD parameter package; RESET_LIMIT and MIN_RATIO are instance parameters.
REQ-029 The mirror phase counter SHALL be one sub-module, cd_phase_mirror (inputs clk, rst_n, limit; output wrap). The FSM, shadow and limit registers SHALL remain in cd_limit_ctrl.

Verification (WIDTH=8, RESET_LIMIT=4, MIN_RATIO=2)
REQ-030 Reset: rst_n low, then released -> limit=4, req_ready=1, busy=0, phase counts 0,1,2,3,0.
REQ-031 Accept 10 at phase 1 -> busy=1 for 2 cycles; at the phase-3 edge limit=10 and phase=0; upd_done high 1 cycle; req_ready=1 the next cycle.
REQ-032 Accept 1 -> err high 1 cycle; limit stays 4; busy stays 0; req_ready stays 1.
REQ-033 Hold req_valid with 6 while PENDING on 10 -> not accepted until req_ready=1; after acceptance, limit=6 exactly 10 cycles after the 10 was applied.
REQ-034 rst_n low 1 cycle during PENDING on 200 -> limit=4, busy=0, no upd_done after release.
REQ-035 Accept 255 -> phase reaches 254 then wraps to 0; no overflow; a following request is applied at that wrap.
